// File: rtl/ioctl_bios_loader.sv
// BIOS image loader: captures host ioctl download bytes, buffers them in a small
// FIFO and writes them into the BIOS ROM window, flagging completion or error.
module ioctl_bios_loader #(
    parameter int unsigned INDEX      = 0,
    parameter int unsigned BIOS_SIZE  = 65536,
    parameter logic [19:0] ROM_BASE   = 20'hF0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        bios_loaded,
    output logic        load_error
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned HI_WATER = FIFO_DEPTH - 1;
    localparam logic [AW:0] DEPTH_W  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] HI_W     = HI_WATER[AW:0];
    localparam logic [24:0] SIZE_A   = BIOS_SIZE[24:0];
    localparam logic [20:0] SIZE_C   = BIOS_SIZE[20:0];
    localparam logic [20:0] CNT_SAT  = 21'h100000;
    localparam logic [7:0]  IDX_W    = INDEX[7:0];

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_req_t;

    state_t                     state;
    wr_req_t [FIFO_DEPTH-1:0]   fifo_q;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count, count_n;
    logic [20:0]                byte_cnt;
    logic                       err, sel, sel_q;
    logic                       load_wr, in_range, full, push, pop;

    assign sel      = ioctl_download && (ioctl_index == IDX_W);
    assign load_wr  = (state == LOAD) && sel && ioctl_wr;
    assign in_range = ioctl_addr < SIZE_A;
    assign full     = (count == DEPTH_W);
    assign push     = load_wr && in_range && !full;
    assign pop      = mem_we && mem_ready;

    // The head entry drives the memory port directly, so it holds during a stall.
    assign mem_addr = fifo_q[rd_ptr].addr;
    assign mem_data = fifo_q[rd_ptr].data;

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + 1'b1;
        else if (!push && pop)
            count_n = count - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            fifo_q      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            byte_cnt    <= '0;
            err         <= 1'b0;
            sel_q       <= 1'b0;
            mem_we      <= 1'b0;
            ioctl_wait  <= 1'b0;
            bios_loaded <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            sel_q  <= sel;
            count  <= count_n;
            mem_we <= (count_n != '0);

            if (push) begin
                fifo_q[wr_ptr].addr <= ROM_BASE + ioctl_addr[19:0];
                fifo_q[wr_ptr].data <= ioctl_dout;
                wr_ptr              <= wr_ptr + 1'b1;
                if (byte_cnt != CNT_SAT)
                    byte_cnt <= byte_cnt + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Out-of-range address or overflow: byte is dropped, image is bad.
            if (load_wr && !push)
                err <= 1'b1;

            // One cycle of lag is covered by throttling one entry below full.
            ioctl_wait <= ((state == LOAD) || (state == DRAIN)) && (count >= HI_W);

            case (state)
                IDLE: begin
                    if (sel && !sel_q) begin
                        state       <= LOAD;
                        bios_loaded <= 1'b0;
                        load_error  <= 1'b0;
                        byte_cnt    <= '0;
                        err         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!sel)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= DONE;
                        if ((byte_cnt == SIZE_C) && !err)
                            bios_loaded <= 1'b1;
                        else
                            load_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ioctl_bios_loader.md
Name: ioctl_bios_loader

Overview:
- Sits between the host ioctl download port and the system memory write path.
- Captures BIOS image bytes streamed by the host and buffers them in a small FIFO.
- Writes the buffered bytes into the BIOS ROM window of system memory.
- Throttles the host with ioctl_wait and raises bios_loaded once a complete image has been committed; that flag gates the CPU out of reset.

Parameters:
- INDEX, 0, ioctl_index value that selects the BIOS image; other indices are ignored.
- BIOS_SIZE, 65536, required image length in bytes (power of two, at most 2^20).
- ROM_BASE, 20'hF0000, physical base address of the BIOS window.
- FIFO_DEPTH, 4, byte FIFO depth (power of two, at least 2).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  host download active
- ioctl_index  in  8  image selector
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_addr  in  25  byte offset within the image
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  host must hold off the next ioctl_wr
- mem_addr  out  20  write address
- mem_data  out  8  write data
- mem_we  out  1  write request (valid)
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- bios_loaded  out  1  a complete image has been committed
- load_error  out  1  the last download was short or had an out-of-range byte

Behaviour:
- Reset values: ioctl_wait=0, mem_we=0, mem_addr=0, mem_data=0, bios_loaded=0, load_error=0, FIFO empty, state IDLE, byte counter 0.
- Reset mid-download: discard the FIFO and all counters. The host stream is not resynchronised.
- Qualifier: sel = ioctl_download && ioctl_index==INDEX.
- State IDLE, on the rising edge of sel:
  - go to LOAD;
  - clear bios_loaded, load_error and the byte counter.
- State LOAD, for each ioctl_wr with sel:
  - if ioctl_addr < BIOS_SIZE, push {ROM_BASE + ioctl_addr[19:0], ioctl_dout} into the FIFO and increment the byte counter;
  - otherwise drop the byte and set the sticky error bit;
  - this address arithmetic is 20-bit and wraps modulo 2^20.
- FIFO overflow: ioctl_wr while the FIFO is full drops the byte and sets the error bit. This cannot happen while the host honours ioctl_wait.
- ioctl_wait:
  - registered; asserted on the cycle after the FIFO count reaches FIFO_DEPTH-1;
  - deasserted on the cycle after the count falls below FIFO_DEPTH-1;
  - forced to 0 in IDLE and DONE.
- Memory side:
  - mem_we=1 whenever the FIFO is non-empty, with mem_addr/mem_data taken from the FIFO head;
  - pop when mem_we && mem_ready;
  - mem_addr and mem_data hold stable while mem_we && !mem_ready;
  - latency from ioctl_wr to mem_we is 1 cycle when the FIFO was empty;
  - a push and a pop in the same cycle leave the count unchanged.
- LOAD -> DRAIN on the falling edge of sel, either download dropping or index changing.
- DRAIN -> DONE when the FIFO is empty and no write is pending.
- On entering DONE:
  - bios_loaded=1 if the byte counter == BIOS_SIZE and the error bit is clear;
  - otherwise load_error=1 and bios_loaded stays 0.
- DONE -> IDLE next cycle. bios_loaded and load_error hold until the next selected download starts.
- Byte counter is 21 bits and saturates at 2^20; duplicate addresses still count.
- Downloads with other indices are ignored entirely: no writes, flags unchanged, ioctl_wait=0.

Test Plan:
- Full image with BIOS_SIZE=16, mem_ready always 1: 16 writes at 0..15 -> 16 mem writes at F0000..F000F with matching data; bios_loaded=1 one cycle after the last write retires; load_error=0.
- Backpressure: mem_ready held 0 for 10 cycles while the host bursts writes -> ioctl_wait=1 after the FIFO count hits 3; mem_addr/mem_data stable while stalled; no byte lost; final image correct.
- Short image: 15 of 16 bytes, then download drops -> 15 writes, bios_loaded=0, load_error=1.
- Out-of-range byte: ioctl_addr=16 with BIOS_SIZE=16 -> no mem write for it; load_error=1 at the end.
- Wrong index: ioctl_index=1 download -> mem_we never asserts; bios_loaded keeps its previous value.
- Reset asserted after 5 bytes with 2 still in the FIFO -> next cycle mem_we=0, FIFO empty, state IDLE; a following complete download succeeds.
